// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg
//   Shared cbus types and arbiter constants.
//   cbus_req_t  : upstream/downstream request (valid, direction, address,
//                 beat count, byte strobes, write data).
//   cbus_resp_t : response beat (ready, last, read data).
//   arb_state_t : arbiter FSM state.
//   len counts beats: 0 and 1 both mean a single-beat transaction.
package cbus_arbiter_pkg;

    localparam int CBUS_ARB_MAX_INPUTS = 8;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arb_select.sv
// cbus_arb_select
//   Combinational winner search over a request-valid vector.  The search
//   begins at start_i and wraps; the first set bit wins.  start_i = 0 gives
//   plain fixed priority (lowest index first).
//   Ports:
//     valid_i     : one valid bit per requester
//     start_i     : index where the search begins (must be < NUM_INPUTS)
//     winner_o    : winning index (0 when nothing is valid)
//     any_valid_o : at least one requester is valid
module cbus_arb_select
    import cbus_arbiter_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid_i,
    input  logic [SEL_W-1:0]      start_i,
    output logic [SEL_W-1:0]      winner_o,
    output logic                  any_valid_o
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = start_i;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!any_valid_o && valid_i[idx]) begin
                winner_o    = idx;
                any_valid_o = 1'b1;
            end
            // Explicit wrap: NUM_INPUTS need not be a power of two.
            idx = (idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter
//   Shares one downstream cbus port between NUM_INPUTS (2..8) requesters.
//   A grant is held for a whole transaction (all burst beats) and released
//   on the beat carrying ready=1 and last=1.  Arbitration costs one IDLE
//   cycle, so consecutive transactions are always separated by one cycle.
//   Build option: define CBUS_ARB_ROUND_ROBIN_EN for round-robin selection
//   (search starts after the previous grant); otherwise fixed priority,
//   lowest index first.
//   Ports:
//     clk    : system clock
//     resetn : asynchronous active-low reset
//     ireqs  : upstream requests, one per requester
//     iresps : upstream responses; only the granted entry is non-zero
//     oreq   : downstream request (granted requester, passed through)
//     oresp  : downstream response
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int  NUM_INPUTS = 2,
    parameter type req_t      = cbus_req_t,
    parameter type resp_t     = cbus_resp_t
) (
    input  logic  clk,
    input  logic  resetn,
    input  req_t  ireqs  [NUM_INPUTS],
    output resp_t iresps [NUM_INPUTS],
    output req_t  oreq,
    input  resp_t oresp
);

    localparam int SEL_W = $clog2(NUM_INPUTS);

    arb_state_t            state_q;
    logic [SEL_W-1:0]      sel_q;
    logic [NUM_INPUTS-1:0] valid_vec;
    logic [SEL_W-1:0]      start;
    logic [SEL_W-1:0]      winner;
    logic                  any_valid;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] last_sel_q;

    assign start = (last_sel_q == SEL_W'(NUM_INPUTS - 1)) ? '0 : last_sel_q + SEL_W'(1);
`else
    assign start = '0;
`endif

    cbus_arb_select #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_select (
        .valid_i     (valid_vec),
        .start_i     (start),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sel_q      <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            last_sel_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        sel_q      <= winner;
                        state_q    <= BUSY;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                        last_sel_q <= winner;
`endif
                    end
                end
                BUSY: begin
                    // Requests arriving on the completing beat wait for IDLE.
                    if (oresp.ready && oresp.last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pure routing: nothing is buffered.  Because state_q resets
    // asynchronously, oreq.valid drops the moment resetn falls.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
            if (state_q == BUSY && sel_q == SEL_W'(i)) begin
                oreq      = ireqs[i];
                iresps[i] = oresp;
            end
        end
    end

endmodule
